// File: rtl/delta_propagate_if.sv
// delta_propagate_if: stream bundle for the delta propagation stage.
//   AS_Weight : NP x NC weight matrix, w[p][c] at p*NC*WF + c*WF
//   AS_Delta1 : current-layer delta vector, delta1[c] at c*WF
//   AS_State0 : previous-layer state vector, state0[p] at p*WF
//   BM_Delta0 : previous-layer delta result, delta0[p] at p*WF
// slave  : view of the delta_propagate block (consumes AS_*, produces BM_*)
// master : view of the surrounding pipeline / testbench
interface delta_propagate_if #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WF = 4
);
    logic                iValid_AS_Weight;
    logic                oReady_AS_Weight;
    logic [NP*NC*WF-1:0] iData_AS_Weight;
    logic                iValid_AS_Delta1;
    logic                oReady_AS_Delta1;
    logic [NC*WF-1:0]    iData_AS_Delta1;
    logic                iValid_AS_State0;
    logic                oReady_AS_State0;
    logic [NP*WF-1:0]    iData_AS_State0;
    logic                oValid_BM_Delta0;
    logic                iReady_BM_Delta0;
    logic [NP*WF-1:0]    oData_BM_Delta0;

    modport slave (
        input  iValid_AS_Weight, iData_AS_Weight,
        output oReady_AS_Weight,
        input  iValid_AS_Delta1, iData_AS_Delta1,
        output oReady_AS_Delta1,
        input  iValid_AS_State0, iData_AS_State0,
        output oReady_AS_State0,
        output oValid_BM_Delta0, oData_BM_Delta0,
        input  iReady_BM_Delta0
    );

    modport master (
        output iValid_AS_Weight, iData_AS_Weight,
        input  oReady_AS_Weight,
        output iValid_AS_Delta1, iData_AS_Delta1,
        input  oReady_AS_Delta1,
        output iValid_AS_State0, iData_AS_State0,
        input  oReady_AS_State0,
        input  oValid_BM_Delta0, oData_BM_Delta0,
        output iReady_BM_Delta0
    );
endinterface

// File: rtl/delta_propagate.sv
// delta_propagate: backward-pass stage computing
//   delta0[p] = ReLU'(state0[p]) * sat((sum_c w[p][c]*delta1[c]) >>> WF)
// using an NC-cycle serial MAC with NP lanes in parallel.
// Ports:
//   iCLK  : clock, rising edge
//   iRST  : asynchronous active-low reset
//   bus   : delta_propagate_if.slave (three joined input streams, one output stream)

// One output lane: accumulator, floor shift, saturation and ReLU' mask.
module delta_propagate_lane #(
    parameter int WF = 4,
    parameter int AW = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic [WF-1:0] w,
    input  logic [WF-1:0] d,
    input  logic [WF-1:0] s0,
    output logic [WF-1:0] res
);
    localparam logic signed [AW-1:0] SMAX = {{(AW-WF+1){1'b0}}, {(WF-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WF+1){1'b1}}, {(WF-1){1'b0}}};

    logic signed [2*WF-1:0] w_x, d_x, prod;
    logic signed [AW-1:0]   acc, acc_nxt, sh;
    logic        [WF-1:0]   sat;
    logic                   pos;

    // Sign-extend before multiplying so the full 2*WF product is exact.
    assign w_x     = {{WF{w[WF-1]}}, w};
    assign d_x     = {{WF{d[WF-1]}}, d};
    assign prod    = w_x * d_x;
    assign acc_nxt = acc + {{(AW-2*WF){prod[2*WF-1]}}, prod};
    assign sh      = acc_nxt >>> WF;
    assign pos     = !s0[WF-1] && (s0 != '0);

    always_comb begin
        sat = sh[WF-1:0];
        if (sh > SMAX)      sat = SMAX[WF-1:0];
        else if (sh < SMIN) sat = SMIN[WF-1:0];
    end

    // The result register is loaded on the final MAC edge so the output
    // is stable for the whole OUT phase.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            acc <= '0;
            res <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
            if (last) res <= pos ? sat : '0;
        end
    end
endmodule

module delta_propagate #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WF = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    delta_propagate_if.slave bus
);
    localparam int CW = $clog2(NC) + 1;
    localparam int AW = 2*WF + CW;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [NP*NC*WF-1:0]     w_q;
    logic [NC*WF-1:0]        d1_q;
    logic [NP*WF-1:0]        s0_q;
    logic                    valid_q;
    logic                    join_ok;
    logic                    last;
    logic [WF-1:0]           d_sel;
    logic [NP-1:0][WF-1:0]   w_sel;
    logic [NP-1:0][WF-1:0]   res;

    // All three streams transfer together; iRST gating keeps readies low in reset.
    assign join_ok = (state == IDLE) && iRST && bus.iValid_AS_Weight &&
                     bus.iValid_AS_Delta1 && bus.iValid_AS_State0;
    assign last    = (cnt == CW'(NC-1));

    assign bus.oReady_AS_Weight = join_ok;
    assign bus.oReady_AS_Delta1 = join_ok;
    assign bus.oReady_AS_State0 = join_ok;
    assign bus.oValid_BM_Delta0 = valid_q;
    assign bus.oData_BM_Delta0  = res;

    // Column select for the current MAC step.
    always_comb begin
        d_sel = '0;
        w_sel = '0;
        for (int c = 0; c < NC; c++) begin
            if (cnt == CW'(c)) begin
                d_sel = d1_q[c*WF +: WF];
                for (int p = 0; p < NP; p++)
                    w_sel[p] = w_q[p*NC*WF + c*WF +: WF];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            w_q     <= '0;
            d1_q    <= '0;
            s0_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (join_ok) begin
                    w_q   <= bus.iData_AS_Weight;
                    d1_q  <= bus.iData_AS_Delta1;
                    s0_q  <= bus.iData_AS_State0;
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state   <= OUT;
                        valid_q <= 1'b1;
                    end
                end
                OUT: if (bus.iReady_BM_Delta0) begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_lane
        delta_propagate_lane #(.WF(WF), .AW(AW)) u_lane (
            .iCLK (iCLK),
            .iRST (iRST),
            .clr  (join_ok),
            .en   (state == MAC),
            .last (last),
            .w    (w_sel[p]),
            .d    (d_sel),
            .s0   (s0_q[p*WF +: WF]),
            .res  (res[p])
        );
    end
endmodule

// File: tb/tb_delta_propagate.sv
// tb_delta_propagate: table-driven vectors plus hand sequences for join,
// backpressure, back-to-back throughput and reset abort. Expected results
// go into a scoreboard queue at the join and are popped on output transfer.
module tb_delta_propagate;
    localparam int NP = 2;
    localparam int NC = 2;
    localparam int WF = 8;

    typedef struct packed {
        logic [31:0] w;
        logic [15:0] d;
        logic [15:0] s;
        logic [15:0] e;
    } vec_t;

    logic clk, rst;
    int   total, passed, cyc;
    logic [15:0] exp_q[$];
    int   joins[$];
    vec_t tv [7];

    delta_propagate_if #(.NP(NP), .NC(NC), .WF(WF)) bus();

    delta_propagate #(.NP(NP), .NC(NC), .WF(WF)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic all_rdy();
        return bus.oReady_AS_Weight && bus.oReady_AS_Delta1 && bus.oReady_AS_State0;
    endfunction

    function automatic logic [2:0] rdys();
        return {bus.oReady_AS_Weight, bus.oReady_AS_Delta1, bus.oReady_AS_State0};
    endfunction

    task automatic set_data(input vec_t v);
        bus.iData_AS_Weight = v.w;
        bus.iData_AS_Delta1 = v.d;
        bus.iData_AS_State0 = v.s;
    endtask

    task automatic set_valid(input logic vw, input logic vd, input logic vs);
        bus.iValid_AS_Weight = vw;
        bus.iValid_AS_Delta1 = vd;
        bus.iValid_AS_State0 = vs;
    endtask

    // Waits (at negedges) until the join is offered; returns 0 on timeout.
    task automatic wait_join(output logic ok);
        int n = 0;
        @(negedge clk);
        while (!all_rdy() && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = all_rdy();
        if (!ok) chk("join_timeout", 32'd0, 32'd1);
    endtask

    // Called just after a posedge. Performs one transaction with iReady=1
    // and checks the join-to-valid latency.
    task automatic run_txn(input vec_t v);
        logic ok;
        int   lat;
        set_data(v);
        set_valid(1'b1, 1'b1, 1'b1);
        wait_join(ok);
        if (ok) exp_q.push_back(v.e);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0, 1'b0);
        if (!ok) return;
        @(negedge clk);
        lat = 0;
        while (!bus.oValid_BM_Delta0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NC);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (all_rdy()) joins.push_back(cyc);
            if (bus.oValid_BM_Delta0 && bus.iReady_BM_Delta0) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("delta0", bus.oData_BM_Delta0, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic        ok;
        int          jn, n;
        logic [15:0] e;
        total = 0; passed = 0; cyc = 0;

        // {w11,w10,w01,w00}, {d1,d0}, {s1,s0}, {o1,o0}
        tv[0] = '{32'h20C0_4040, 16'h4040, 16'h0501, 16'hF820}; // basic
        tv[1] = '{32'h20C0_4040, 16'h4040, 16'hFD00, 16'h0000}; // both masked
        tv[2] = '{32'h20C0_4040, 16'h4040, 16'h0001, 16'h0020}; // lane1 masked
        tv[3] = '{32'h8080_8080, 16'h8080, 16'h0101, 16'h7F7F}; // +sat
        tv[4] = '{32'h8080_8080, 16'h7F7F, 16'h0101, 16'h8181}; // -127 exact
        tv[5] = '{32'h0100_0001, 16'h03FF, 16'h0101, 16'h00FF}; // floor -1/256
        tv[6] = '{32'h00FF_7F7F, 16'h7F7F, 16'h0101, 16'hFF7E}; // 126, -1

        rst = 1'b0;
        bus.iReady_BM_Delta0 = 1'b0;
        set_valid(1'b0, 1'b0, 1'b0);
        set_data('0);

        // Reset state: readies stay low even with all valids asserted.
        repeat (2) @(negedge clk);
        set_valid(1'b1, 1'b1, 1'b1);
        #1;
        chk("reset_ready", rdys(), 3'b000);
        chk("reset_valid", bus.oValid_BM_Delta0, 1'b0);
        chk("reset_data", bus.oData_BM_Delta0, 16'h0000);
        set_valid(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.iReady_BM_Delta0 = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_txn(tv[i]);

        // Partial valids, then join and output backpressure.
        @(posedge clk); #1;
        bus.iReady_BM_Delta0 = 1'b0;
        set_data(tv[0]);
        set_valid(1'b1, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("partial_valid", {bus.oValid_BM_Delta0, rdys()}, 4'b0000);
        end
        @(posedge clk); #1;
        set_valid(1'b1, 1'b1, 1'b1);
        wait_join(ok);
        if (ok) exp_q.push_back(tv[0].e);
        n = 0;
        @(negedge clk);
        while (!bus.oValid_BM_Delta0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            chk("hold_ctl", {bus.oValid_BM_Delta0, rdys()}, 4'b1000);
            chk("hold_data", bus.oData_BM_Delta0, tv[0].e);
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0, 1'b0);
        bus.iReady_BM_Delta0 = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: valids held high, joins must be NC+2 apart.
        jn = joins.size();
        set_data(tv[3]);
        set_valid(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_join(ok);
            if (ok) exp_q.push_back(tv[3+k].e);
            @(posedge clk); #1;
            if (k < 2) set_data(tv[4+k]);
            else set_valid(1'b0, 1'b0, 1'b0);
        end
        chk("b2b_joins", joins.size() - jn, 3);
        if (joins.size() - jn >= 3) begin
            chk("b2b_gap0", joins[jn+1] - joins[jn], NC + 2);
            chk("b2b_gap1", joins[jn+2] - joins[jn+1], NC + 2);
        end

        // Reset abort after the first MAC edge; the aborted result never appears.
        n = 0;
        while (bus.oValid_BM_Delta0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        set_data(tv[3]);
        set_valid(1'b1, 1'b1, 1'b1);
        wait_join(ok);
        @(posedge clk); #1;         // join edge T
        set_valid(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;         // MAC edge T+1
        rst = 1'b0;
        set_valid(1'b1, 1'b1, 1'b1);
        #1;
        chk("abort_ctl", {bus.oValid_BM_Delta0, rdys()}, 4'b0000);
        chk("abort_data", bus.oData_BM_Delta0, 16'h0000);
        @(posedge clk); #1;
        set_valid(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(tv[2]);
        run_txn(tv[6]);

        // Drain the scoreboard.
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("FAIL missing_out: got none expected %h", e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
